// File: rtl/io_input_controller.sv
// Memory-mapped controller for two debounced push-button input channels.
// Latches the switch value on each press and arbitrates pending channels round-robin.
module io_input_controller #(
  parameter logic [15:0] BASE_ADDR = 16'hFFF0,
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pin_1,
  input  logic        pb_1,
  input  logic [15:0] pin_2,
  input  logic        pb_2,
  input  logic [15:0] addr,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic        sel,
  output logic        irq
);

  typedef enum logic [1:0] {
    OFF_STATUS = 2'd0,
    OFF_DATA1  = 2'd1,
    OFF_DATA2  = 2'd2,
    OFF_NEXT   = 2'd3
  } reg_off_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [15:0] off_full;
  reg_off_e    off;

  // Modular subtraction keeps the range check correct for any BASE_ADDR.
  assign off_full = addr - BASE_ADDR;
  assign sel      = (off_full[15:2] == 14'd0);
  assign off      = reg_off_e'(off_full[1:0]);

  logic [1:0]       pb_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       db_q, db_d;
  logic [1:0]       press;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign pb_raw = {pb_2, pb_1};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cnt_d[c] = '0;
      db_d[c]  = db_q[c];
      press[c] = 1'b0;
      if (sync2_q[c] != db_q[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          db_d[c]  = ~db_q[c];
          press[c] = ~db_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  logic [1:0]  valid_q, valid_d;
  logic [1:0]  ovr_q, ovr_d;
  logic [1:0]  clr_v;
  logic [15:0] pin_in [2];
  logic [15:0] data_q [2];
  logic [15:0] data_d [2];
  logic        rr_q, rr_d;
  logic        irq_q;
  logic        rd_hit, any_v, gnt2, clr_ovr;

  assign pin_in[0] = pin_1;
  assign pin_in[1] = pin_2;

  // rr_q = 1 favours channel 2 when both channels are pending.
  assign rd_hit   = rd_en & sel;
  assign any_v    = |valid_q;
  assign gnt2     = valid_q[1] & (~valid_q[0] | rr_q);
  assign clr_ovr  = rd_hit & (off == OFF_STATUS);
  assign clr_v[0] = rd_hit & ((off == OFF_DATA1) | ((off == OFF_NEXT) & any_v & ~gnt2));
  assign clr_v[1] = rd_hit & ((off == OFF_DATA2) | ((off == OFF_NEXT) & gnt2));
  assign rr_d     = (rd_hit & (off == OFF_NEXT) & any_v) ? ~gnt2 : rr_q;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      valid_d[c] = press[c] | (valid_q[c] & ~clr_v[c]);
      ovr_d[c]   = (press[c] & valid_q[c] & ~clr_v[c]) | (ovr_q[c] & ~clr_ovr);
      data_d[c]  = press[c] ? pin_in[c] : data_q[c];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      valid_q <= '0;
      ovr_q   <= '0;
      rr_q    <= 1'b0;
      irq_q   <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        cnt_q[c]  <= '0;
        data_q[c] <= '0;
      end
    end else begin
      sync1_q <= pb_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      rr_q    <= rr_d;
      irq_q   <= |valid_q;
      for (int c = 0; c < 2; c++) begin
        cnt_q[c]  <= cnt_d[c];
        data_q[c] <= data_d[c];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel) begin
      unique case (off)
        OFF_STATUS: rd_data = {11'b0, gnt2, ovr_q[1], ovr_q[0], valid_q[1], valid_q[0]};
        OFF_DATA1:  rd_data = data_q[0];
        OFF_DATA2:  rd_data = data_q[1];
        OFF_NEXT:   rd_data = any_v ? (gnt2 ? data_q[1] : data_q[0]) : 16'h0000;
        default:    rd_data = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_io_input_controller.sv
// Self-checking bench for io_input_controller: directed scenarios plus random traffic
// compared against a sample-history behavioural model.
module tb_io_input_controller;

  localparam int DB   = 4;
  localparam int BASE = 'hFFF0;

  logic        clk;
  logic        rst;
  logic [15:0] pin_1, pin_2, addr, rd_data;
  logic        pb_1, pb_2, rd_en, sel, irq;

  int n_checks = 0;
  int n_fail   = 0;

  io_input_controller #(
    .BASE_ADDR(16'hFFF0),
    .DB_CYCLES(DB),
    .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .pin_1(pin_1), .pb_1(pb_1),
    .pin_2(pin_2), .pb_2(pb_2),
    .addr(addr), .rd_en(rd_en),
    .rd_data(rd_data), .sel(sel), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: hist[c][0] is the newest button sample; a level is accepted once the
  // synchronised samples (two edges old and older) disagree with it DB times in a row.
  bit          hist [2][DB+1];
  bit          m_db [2];
  bit          m_valid [2];
  bit          m_ovr [2];
  logic [15:0] m_data [2];
  bit          m_rr;
  bit          m_irq;

  function automatic int grant_ch();
    if (m_valid[0] && m_valid[1]) return m_rr ? 1 : 0;
    if (m_valid[0]) return 0;
    if (m_valid[1]) return 1;
    return -1;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    int g, off;
    off = int'(a) - BASE;
    if (off < 0 || off > 3) return 16'h0000;
    g = grant_ch();
    case (off)
      0: return {11'b0, 1'(g == 1), m_ovr[1], m_ovr[0], m_valid[1], m_valid[0]};
      1: return m_data[0];
      2: return m_data[1];
      default: return (g < 0) ? 16'h0000 : m_data[g];
    endcase
  endfunction

  function automatic bit exp_sel(input logic [15:0] a);
    return (int'(a) >= BASE) && (int'(a) <= BASE + 3);
  endfunction

  // Advances the model by one clock edge from the current inputs, then waits for the edge.
  task automatic tick();
    bit          pb_s [2];
    logic [15:0] pin_s [2];
    bit          flip, press, clr, hit;
    int          g, off;
    pb_s[0] = pb_1;   pb_s[1] = pb_2;
    pin_s[0] = pin_1; pin_s[1] = pin_2;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_valid[c] = 0; m_ovr[c] = 0; m_data[c] = '0; m_db[c] = 0;
        for (int j = 0; j <= DB; j++) hist[c][j] = 0;
      end
      m_rr  = 0;
      m_irq = 0;
    end else begin
      off   = int'(addr) - BASE;
      hit   = rd_en && off >= 0 && off <= 3;
      g     = grant_ch();
      m_irq = m_valid[0] | m_valid[1];
      for (int c = 0; c < 2; c++) begin
        flip = 1;
        for (int j = 1; j <= DB; j++) if (hist[c][j] == m_db[c]) flip = 0;
        press = flip && !m_db[c];
        if (flip) m_db[c] = !m_db[c];
        for (int j = DB; j >= 1; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = pb_s[c];
        clr = hit && (off == c + 1 || (off == 3 && g == c));
        if (press && m_valid[c] && !clr) m_ovr[c] = 1;
        else if (hit && off == 0)        m_ovr[c] = 0;
        if (press) begin
          m_valid[c] = 1;
          m_data[c]  = pin_s[c];
        end else if (clr) begin
          m_valid[c] = 0;
        end
      end
      if (hit && off == 3 && g >= 0) m_rr = (g == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    addr  = 16'hFFF0;
    rd_en = 1'b0;
    #1;
  endtask

  // Holds the selected buttons long enough to qualify a press, then a release.
  task automatic pulse_pb(input bit c1, input bit c2, input logic [15:0] v1, input logic [15:0] v2);
    if (c1) pin_1 = v1;
    if (c2) pin_2 = v2;
    pb_1 = c1;
    pb_2 = c2;
    repeat (DB + 2) tick();
    pb_1 = 1'b0;
    pb_2 = 1'b0;
    repeat (DB + 2) tick();
  endtask

  task automatic read_clear(input logic [15:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; pb_1 = 0; pb_2 = 0; pin_1 = '0; pin_2 = '0;
    drive_idle();
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_status: got %h expected 0000", rd_data);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    n_checks++;
    if (sel !== 1'b1) begin
      n_fail++; $display("FAIL reset_sel_base: got %b expected 1", sel);
    end
    addr = 16'hFFF1; #1;
    n_checks++;
    if (rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data1: got %h expected 0000", rd_data);
    end
    drive_idle();
  endtask

  task automatic test_debounce_glitch();
    int  rises, rise_edge;
    bit  prev, irq_at_rise, irq_after;
    rises = 0; rise_edge = -1; irq_at_rise = 1; irq_after = 0;
    pin_1 = 16'hABCD;
    pb_1 = 1; tick();
    pb_1 = 0; tick();
    pb_1 = 1; tick();
    prev = rd_data[0];
    for (int e = 2; e <= 8; e++) begin
      tick();
      if (rd_data[0] && !prev) begin
        rises++;
        rise_edge = e;
      end
      if (e == 6) irq_at_rise = irq;
      if (e == 7) irq_after = irq;
      prev = rd_data[0];
      n_checks++;
      if (rd_data !== exp_rd(addr)) begin
        n_fail++; $display("FAIL glitch_status_e%0d: got %h expected %h", e, rd_data, exp_rd(addr));
      end
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++; $display("FAIL glitch_rises: got %0d expected 1", rises);
    end
    n_checks++;
    if (rise_edge != DB + 2) begin
      n_fail++; $display("FAIL glitch_latency: got %0d expected %0d", rise_edge, DB + 2);
    end
    n_checks++;
    if (irq_at_rise !== 1'b0 || irq_after !== 1'b1) begin
      n_fail++; $display("FAIL glitch_irq: got %b%b expected 01", irq_at_rise, irq_after);
    end
    addr = 16'hFFF1; #1;
    n_checks++;
    if (rd_data !== 16'hABCD) begin
      n_fail++; $display("FAIL glitch_data1: got %h expected abcd", rd_data);
    end
    pb_1 = 0;
    repeat (DB + 2) tick();
    read_clear(16'hFFF1);
  endtask

  task automatic test_overrun();
    pulse_pb(1, 0, 16'h0001, 16'h0000);
    pulse_pb(1, 0, 16'h0002, 16'h0000);
    n_checks++;
    if (rd_data !== 16'h0005) begin
      n_fail++; $display("FAIL ovr_status: got %h expected 0005", rd_data);
    end
    addr = 16'hFFF1; #1;
    n_checks++;
    if (rd_data !== 16'h0002) begin
      n_fail++; $display("FAIL ovr_data1: got %h expected 0002", rd_data);
    end
    read_clear(16'hFFF0);
    n_checks++;
    if (rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL ovr_status_after_read: got %h expected 0001", rd_data);
    end
    read_clear(16'hFFF1);
    n_checks++;
    if (rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL ovr_cleared: got %h expected 0000", rd_data);
    end
  endtask

  task automatic test_round_robin();
    pulse_pb(1, 1, 16'h1111, 16'h2222);
    addr = 16'hFFF3; rd_en = 1; #1;
    n_checks++;
    if (rd_data !== 16'h1111) begin
      n_fail++; $display("FAIL rr_next1: got %h expected 1111", rd_data);
    end
    tick();
    drive_idle();
    n_checks++;
    if (rd_data !== 16'h0012) begin
      n_fail++; $display("FAIL rr_status: got %h expected 0012", rd_data);
    end
    addr = 16'hFFF3; rd_en = 1; #1;
    n_checks++;
    if (rd_data !== 16'h2222) begin
      n_fail++; $display("FAIL rr_next2: got %h expected 2222", rd_data);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL rr_irq_lag: got %b expected 1", irq);
    end
    n_checks++;
    if (rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL rr_next_empty: got %h expected 0000", rd_data);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL rr_irq_drop: got %b expected 0", irq);
    end
    drive_idle();
    n_checks++;
    if (rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL rr_status_empty: got %h expected 0000", rd_data);
    end
  endtask

  task automatic test_press_vs_clear();
    pulse_pb(0, 1, 16'h0000, 16'h3333);
    pin_2 = 16'h4444;
    pb_2  = 1;
    repeat (DB + 1) tick();
    addr = 16'hFFF2; rd_en = 1; #1;
    n_checks++;
    if (rd_data !== 16'h3333) begin
      n_fail++; $display("FAIL pvc_read_old: got %h expected 3333", rd_data);
    end
    tick();
    rd_en = 0; #1;
    n_checks++;
    if (rd_data !== 16'h4444) begin
      n_fail++; $display("FAIL pvc_data2_new: got %h expected 4444", rd_data);
    end
    addr = 16'hFFF0; #1;
    n_checks++;
    if (rd_data !== 16'h0012) begin
      n_fail++; $display("FAIL pvc_status: got %h expected 0012", rd_data);
    end
    pb_2 = 0;
    repeat (DB + 2) tick();
  endtask

  task automatic test_reset_mid();
    pin_1 = 16'h5555;
    pb_1  = 1;
    repeat (DB) tick();
    rst = 1; tick(); rst = 0; #1;
    n_checks++;
    if (rd_data !== 16'h0000 || irq !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags: got %h/%b expected 0000/0", rd_data, irq);
    end
    repeat (DB + 1) tick();
    n_checks++;
    if (rd_data[0] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_early: got %b expected 0", rd_data[0]);
    end
    tick();
    n_checks++;
    if (rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL rstmid_requalify: got %h expected 0001", rd_data);
    end
    pb_1 = 0;
    repeat (DB + 2) tick();
  endtask

  task automatic test_out_of_range();
    logic [15:0] bad [4];
    bad[0] = 16'h0010; bad[1] = 16'h0011; bad[2] = 16'hFFEF; bad[3] = 16'hFFF4;
    for (int i = 0; i < 4; i++) begin
      addr = bad[i]; rd_en = 1; #1;
      n_checks++;
      if (sel !== 1'b0 || rd_data !== 16'h0000) begin
        n_fail++; $display("FAIL oor_%h: got sel=%b data=%h expected sel=0 data=0000", bad[i], sel, rd_data);
      end
      tick();
    end
    addr = 16'hFFF3; rd_en = 0; #1;
    n_checks++;
    if (sel !== 1'b1 || rd_data !== 16'h5555) begin
      n_fail++; $display("FAIL oor_top_edge: got sel=%b data=%h expected sel=1 data=5555", sel, rd_data);
    end
    drive_idle();
    n_checks++;
    if (rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL oor_no_change: got %h expected 0001", rd_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) pb_1 = ~pb_1;
      if ($urandom_range(0, 9) == 0) pb_2 = ~pb_2;
      pin_1 = 16'($urandom);
      pin_2 = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       addr = 16'hFFEF;
        1:       addr = 16'hFFF4;
        2:       addr = 16'($urandom);
        default: addr = 16'hFFF0 + 16'($urandom_range(0, 3));
      endcase
      rd_en = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      #1;
      n_checks++;
      if (sel !== exp_sel(addr) || rd_data !== exp_rd(addr)) begin
        n_fail++;
        $display("FAIL rand_read_%0d: addr=%h got sel=%b data=%h expected sel=%b data=%h",
                 i, addr, sel, rd_data, exp_sel(addr), exp_rd(addr));
      end
      tick();
      n_checks++;
      if (irq !== m_irq) begin
        n_fail++; $display("FAIL rand_irq_%0d: got %b expected %b", i, irq, m_irq);
      end
    end
    rst = 0;
    drive_idle();
  endtask

  initial begin
    rst = 1; pb_1 = 0; pb_2 = 0; pin_1 = '0; pin_2 = '0; addr = 16'hFFF0; rd_en = 0;
    test_reset();
    test_debounce_glitch();
    test_overrun();
    test_round_robin();
    test_press_vs_clear();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
